// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: CSR master for the Avalon I2C host bridge. Initialises SCL timing,
// turns single-byte register write/read commands into TFR_CMD pushes, polls for
// completion, fetches RX data and returns one response per command, recovering locally
// from NACK, arbitration loss and timeout.
module i2c_cmd_sequencer #(
  parameter int unsigned SCL_LOW_CNT  = 500,
  parameter int unsigned SCL_HIGH_CNT = 500,
  parameter int unsigned SDA_HOLD_CNT = 30,
  parameter int unsigned TIMEOUT_CYC  = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rnw,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_reg,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_nack,
  output logic        rsp_arblost,
  output logic        rsp_timeout,
  output logic [3:0]  csr_address,
  output logic        csr_read,
  output logic        csr_write,
  output logic [31:0] csr_writedata,
  input  logic [31:0] csr_readdata
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  typedef enum logic [4:0] {
    S_INIT_SCLL, S_INIT_SCLH, S_INIT_SDAH, S_INIT_ISR, S_INIT_EN, S_IDLE, S_PUSH,
    S_ISR_RD, S_ISR_WT, S_ISR_CHK, S_STS_RD, S_STS_WT, S_STS_CHK,
    S_LVL_RD, S_LVL_WT, S_LVL_CHK, S_RXL_RD, S_RXL_WT, S_RXL_CHK,
    S_RXD_RD, S_RXD_WT, S_RXD_CHK, S_ABT_DIS, S_ABT_CLR, S_ABT_EN, S_RESP
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_rnw;
  logic [6:0]      r_addr;
  logic [7:0]      r_reg, r_wdata, r_rdata;
  logic [1:0]      r_push_idx;
  logic            r_sts_busy, r_flag_nack, r_flag_arb, r_flag_to;
  logic [CW-1:0]   r_tmo_cnt;
  logic [AW-1:0]   r_csr_address, w_csr_address;
  logic [DW-1:0]   r_csr_writedata, w_csr_writedata, w_push_word;
  logic            r_csr_read, w_csr_read, r_csr_write, w_csr_write;
  logic            r_cmd_ready, w_cmd_ready, r_rsp_valid, w_rsp_valid;
  logic [7:0]      r_rsp_rdata;
  logic            r_rsp_nack, r_rsp_arb, r_rsp_to;
  logic            w_accept, w_isr_err, w_tmo_abort, w_busy, w_poll, w_tmo_exp;
  logic [1:0]      w_push_last;

  assign w_busy      = (r_state >= S_PUSH) && (r_state <= S_RXD_CHK);
  assign w_poll      = (r_state >= S_ISR_RD) && (r_state <= S_RXD_CHK);
  assign w_tmo_exp   = (r_tmo_cnt >= CW'(TIMEOUT_CYC));
  assign w_push_last = r_rnw ? 2'd3 : 2'd2;

  // TFR_CMD word for the current push slot (repeated start on reads)
  always_comb begin
    w_push_word = '0;
    unique case (r_push_idx)
      2'd0: w_push_word = {22'b0, 2'b10, r_addr, 1'b0};
      2'd1: w_push_word = {24'b0, r_reg};
      2'd2: w_push_word = r_rnw ? {22'b0, 2'b10, r_addr, 1'b1} : {22'b0, 2'b01, r_wdata};
      default: w_push_word = {22'b0, 2'b01, 8'h00};
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_INIT_SCLL;
    else       r_state <= w_state_next;
  end

  // next state and next-cycle CSR/handshake outputs
  always_comb begin
    w_state_next    = r_state;
    w_csr_address   = '0;
    w_csr_writedata = '0;
    w_csr_read      = 1'b0;
    w_csr_write     = 1'b0;
    w_cmd_ready     = 1'b0;
    w_rsp_valid     = 1'b0;
    w_accept        = 1'b0;
    w_isr_err       = 1'b0;
    w_tmo_abort     = 1'b0;
    unique case (r_state)
      S_INIT_SCLL: begin w_csr_write = 1'b1; w_csr_address = AW'(8);  w_csr_writedata = DW'(SCL_LOW_CNT);  w_state_next = S_INIT_SCLH; end
      S_INIT_SCLH: begin w_csr_write = 1'b1; w_csr_address = AW'(9);  w_csr_writedata = DW'(SCL_HIGH_CNT); w_state_next = S_INIT_SDAH; end
      S_INIT_SDAH: begin w_csr_write = 1'b1; w_csr_address = AW'(10); w_csr_writedata = DW'(SDA_HOLD_CNT); w_state_next = S_INIT_ISR;  end
      S_INIT_ISR:  begin w_csr_write = 1'b1; w_csr_address = AW'(4);  w_csr_writedata = DW'(32'h1F);      w_state_next = S_INIT_EN;   end
      S_INIT_EN:   begin w_csr_write = 1'b1; w_csr_address = AW'(2);  w_csr_writedata = DW'(32'h1);       w_state_next = S_IDLE;      end
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_accept     = 1'b1;
          w_cmd_ready  = 1'b0;
          w_state_next = S_PUSH;
        end
      end
      S_PUSH: begin
        w_csr_write     = 1'b1;
        w_csr_address   = AW'(0);
        w_csr_writedata = w_push_word;
        if (r_push_idx == w_push_last) w_state_next = S_ISR_RD;
      end
      S_ISR_RD:  begin w_csr_read = 1'b1; w_csr_address = AW'(4); w_state_next = S_ISR_WT; end
      S_ISR_WT:  w_state_next = S_ISR_CHK;
      S_ISR_CHK: begin
        w_isr_err    = csr_readdata[2] | csr_readdata[3];
        w_state_next = w_isr_err ? S_ABT_DIS : S_STS_RD;
      end
      S_STS_RD:  begin w_csr_read = 1'b1; w_csr_address = AW'(5); w_state_next = S_STS_WT; end
      S_STS_WT:  w_state_next = S_STS_CHK;
      S_STS_CHK: w_state_next = S_LVL_RD;
      S_LVL_RD:  begin w_csr_read = 1'b1; w_csr_address = AW'(6); w_state_next = S_LVL_WT; end
      S_LVL_WT:  w_state_next = S_LVL_CHK;
      S_LVL_CHK: begin
        if (r_sts_busy || (csr_readdata != '0)) w_state_next = S_ISR_RD;
        else                                    w_state_next = r_rnw ? S_RXL_RD : S_RESP;
      end
      S_RXL_RD:  begin w_csr_read = 1'b1; w_csr_address = AW'(7); w_state_next = S_RXL_WT; end
      S_RXL_WT:  w_state_next = S_RXL_CHK;
      S_RXL_CHK: w_state_next = (csr_readdata == '0) ? S_RXL_RD : S_RXD_RD;
      S_RXD_RD:  begin w_csr_read = 1'b1; w_csr_address = AW'(1); w_state_next = S_RXD_WT; end
      S_RXD_WT:  w_state_next = S_RXD_CHK;
      S_RXD_CHK: w_state_next = S_RESP;
      S_ABT_DIS: begin w_csr_write = 1'b1; w_csr_address = AW'(2); w_csr_writedata = DW'(32'h0);  w_state_next = S_ABT_CLR; end
      S_ABT_CLR: begin w_csr_write = 1'b1; w_csr_address = AW'(4); w_csr_writedata = DW'(32'h1F); w_state_next = S_ABT_EN;  end
      S_ABT_EN:  begin w_csr_write = 1'b1; w_csr_address = AW'(2); w_csr_writedata = DW'(32'h1);  w_state_next = S_RESP;    end
      S_RESP: begin
        w_rsp_valid  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_INIT_SCLL;
    endcase
    // expiry preempts any poll step, including issuing the next read
    if (w_poll && w_tmo_exp) begin
      w_state_next  = S_ABT_DIS;
      w_csr_read    = 1'b0;
      w_csr_address = '0;
      w_isr_err     = 1'b0;
      w_tmo_abort   = 1'b1;
    end
  end

  // command latch, push index, poll captures, flags and timeout counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rnw <= 1'b0; r_addr <= '0; r_reg <= '0; r_wdata <= '0; r_rdata <= '0;
      r_push_idx <= '0; r_sts_busy <= 1'b0; r_tmo_cnt <= '0;
      r_flag_nack <= 1'b0; r_flag_arb <= 1'b0; r_flag_to <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rnw <= cmd_rnw; r_addr <= cmd_addr; r_reg <= cmd_reg; r_wdata <= cmd_wdata;
        r_rdata <= '0; r_push_idx <= '0; r_tmo_cnt <= '0;
        r_flag_nack <= 1'b0; r_flag_arb <= 1'b0; r_flag_to <= 1'b0;
      end else if (w_busy && !w_tmo_exp) begin
        r_tmo_cnt <= r_tmo_cnt + CW'(1);
      end
      if (r_state == S_PUSH)    r_push_idx <= r_push_idx + 2'd1;
      if (r_state == S_STS_CHK) r_sts_busy <= (csr_readdata != '0);
      if (r_state == S_RXD_CHK && !w_tmo_abort) r_rdata <= csr_readdata[7:0];
      if (w_isr_err) begin
        r_flag_nack <= csr_readdata[2];
        r_flag_arb  <= csr_readdata[3];
      end
      if (w_tmo_abort) r_flag_to <= 1'b1;
    end
  end

  // registered outputs; response fields hold until the next response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csr_address <= '0; r_csr_writedata <= '0; r_csr_read <= 1'b0; r_csr_write <= 1'b0;
      r_cmd_ready <= 1'b0; r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0; r_rsp_nack <= 1'b0; r_rsp_arb <= 1'b0; r_rsp_to <= 1'b0;
    end else begin
      r_csr_address   <= w_csr_address;
      r_csr_writedata <= w_csr_writedata;
      r_csr_read      <= w_csr_read;
      r_csr_write     <= w_csr_write;
      r_cmd_ready     <= w_cmd_ready;
      r_rsp_valid     <= w_rsp_valid;
      if (w_rsp_valid) begin
        r_rsp_rdata <= r_rdata;
        r_rsp_nack  <= r_flag_nack;
        r_rsp_arb   <= r_flag_arb;
        r_rsp_to    <= r_flag_to;
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_nack      = r_rsp_nack;
  assign rsp_arblost   = r_rsp_arb;
  assign rsp_timeout   = r_rsp_to;
  assign csr_address   = r_csr_address;
  assign csr_read      = r_csr_read;
  assign csr_write     = r_csr_write;
  assign csr_writedata = r_csr_writedata;

endmodule
